// File: rtl/uart_rx_os_if.sv
// Receive-side handshake bundle: byte payload with valid/ready flow control.
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_os.sv
// UART receiver with oversampled mid-bit sampling, start-glitch rejection,
// framing-error detection and a one-entry holding register with sticky overrun.
module uart_rx_os #(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  input  logic [13:0]        baud_tick_max,
  uart_rx_os_if.master       rx_if,
  output logic               frame_err,
  output logic               overrun,
  output logic               rx_busy
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SCW-1:0] MID_CNT  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] LAST_CNT = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   rx_prev_q;
  logic [13:0]            tick_cnt_q;
  logic [13:0]            tick_max_q;
  logic [SCW-1:0]         sample_cnt_q;
  logic [BCW-1:0]         bit_cnt_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q;

  logic start_edge, tick, mid_tick, bit_tick, stop_sample, deliver, accept, can_load;

  assign rxs         = sync_q[SYNC_STAGES-1];
  assign start_edge  = (state_q == IDLE) && rx_prev_q && !rxs;
  assign tick        = (tick_cnt_q == tick_max_q);
  assign mid_tick    = tick && (sample_cnt_q == MID_CNT);
  assign bit_tick    = tick && (sample_cnt_q == LAST_CNT);
  assign stop_sample = (state_q == STOP) && bit_tick;
  assign deliver     = stop_sample && rxs;
  assign accept      = valid_q && rx_if.rx_ready;
  assign can_load    = !valid_q || accept;

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign rx_busy        = (state_q != IDLE);

  // Synchronise the asynchronous rx line; idles high out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode driven by the mid-start and end-of-bit sample points.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_edge) state_d = START;
      START: if (mid_tick)   state_d = rxs ? IDLE : DATA;
      DATA:  if (bit_tick && (bit_cnt_q == LAST_BIT)) state_d = STOP;
      STOP:  if (bit_tick)   state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Tick generator, sample/bit counters, shift register and edge-detect history.
  // rx_prev only follows the line in IDLE (and at the stop sample), so a line
  // stuck low after a break must go high before another start is recognised.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_prev_q    <= 1'b1;
      tick_cnt_q   <= '0;
      tick_max_q   <= '0;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
    end else begin
      if (state_q == IDLE || stop_sample) rx_prev_q <= rxs;

      if (state_q == IDLE) begin
        tick_cnt_q <= '0;
        if (start_edge) tick_max_q <= baud_tick_max;
      end else begin
        tick_cnt_q <= tick ? '0 : tick_cnt_q + 14'd1;
      end

      if (state_q == IDLE || (state_q == START && mid_tick) || bit_tick)
        sample_cnt_q <= '0;
      else if (tick)
        sample_cnt_q <= sample_cnt_q + 1'b1;

      if (state_q == START)
        bit_cnt_q <= '0;
      else if (state_q == DATA && bit_tick)
        bit_cnt_q <= bit_cnt_q + 1'b1;

      if (state_q == DATA && bit_tick)
        shreg_q <= {rxs, shreg_q[DATA_BITS-1:1]};
    end
  end

  // Holding register, handshake, overrun and framing-error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= stop_sample && !rxs;
      if (accept) begin
        valid_q <= 1'b0;
        overrun <= 1'b0;
      end
      if (deliver) begin
        if (can_load) begin
          data_q  <= shreg_q;
          valid_q <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: directed frames push expected bytes,
// a negedge monitor pops and compares on every completed handshake.
module tb_uart_rx_os;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic [13:0] btm = 14'd3;
  logic        frame_err, overrun, rx_busy;

  uart_rx_os_if #(.DATA_BITS(8)) bus ();

  uart_rx_os #(.OVERSAMPLE(16), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .baud_tick_max (btm),
    .rx_if         (bus),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         fe_exp  = 0;
  int         cpb     = 64;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Start bit, DATA_BITS LSB first, stop bit; rx is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stopb);
    rx = 1'b0;
    step(cpb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(cpb);
    end
    rx = stopb;
    step(cpb);
  endtask

  task automatic wait_valid(input string name, input int maxc);
    int k;
    k = 0;
    while (!bus.rx_valid && k < maxc) begin
      step(1);
      k++;
    end
    check(name, {31'd0, bus.rx_valid}, 32'd1);
  endtask

  // Monitor: compare delivered bytes in order, flag unexpected events.
  always @(negedge clk) begin
    if (rst && bus.rx_valid && bus.rx_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h expected none", bus.rx_data);
      end else begin
        check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    if (rst && frame_err) begin
      if (fe_exp > 0) fe_exp--;
      else check("unexpected_frame_err", {31'd0, frame_err}, 32'd0);
    end
  end

  initial begin
    bus.rx_ready = 1'b1;
    step(3);
    check("reset rx_valid",  {31'd0, bus.rx_valid}, 32'd0);
    check("reset rx_data",   {24'd0, bus.rx_data}, 32'd0);
    check("reset frame_err", {31'd0, frame_err}, 32'd0);
    check("reset overrun",   {31'd0, overrun}, 32'd0);
    check("reset rx_busy",   {31'd0, rx_busy}, 32'd0);
    rst = 1'b1;
    step(20);

    // 1: single 0xA5, valid for exactly one clk with ready held high
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_valid("t1 valid_timeout", 12 * cpb);
        step(1);
        check("t1 valid_one_clk", {31'd0, bus.rx_valid}, 32'd0);
        check("t1 overrun", {31'd0, overrun}, 32'd0);
      end
    join
    rx = 1'b1;
    step(cpb);
    check("t1 drained", exp_q.size(), 32'd0);

    // 2: 20-clk low glitch is rejected at the mid-start check
    rx = 1'b0;
    step(10);
    check("t2 busy_in_start", {31'd0, rx_busy}, 32'd1);
    step(10);
    rx = 1'b1;
    step(40);
    check("t2 busy_cleared", {31'd0, rx_busy}, 32'd0);
    check("t2 no_valid", {31'd0, bus.rx_valid}, 32'd0);

    // 3: framing error, line held low, then recovery
    fe_exp++;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    step(2000);
    check("t3 frame_err_seen", fe_exp, 32'd0);
    check("t3 idle_while_low", {31'd0, rx_busy}, 32'd0);
    rx = 1'b1;
    step(100);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    rx = 1'b1;
    step(2 * cpb);
    check("t3 drained", exp_q.size(), 32'd0);

    // 4: overrun with consumer stalled
    bus.rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    rx = 1'b1;
    step(2 * cpb);
    check("t4 valid_held", {31'd0, bus.rx_valid}, 32'd1);
    check("t4 data_held", {24'd0, bus.rx_data}, 32'h11);
    check("t4 overrun_set", {31'd0, overrun}, 32'd1);
    bus.rx_ready = 1'b1;
    step(1);
    check("t4 valid_cleared", {31'd0, bus.rx_valid}, 32'd0);
    check("t4 overrun_cleared", {31'd0, overrun}, 32'd0);
    check("t4 drained", exp_q.size(), 32'd0);

    // 5: reset during data bit 4 of 0x77, then a clean 0xFF
    rx = 1'b0;
    step(cpb);
    for (int i = 0; i < 4; i++) begin
      rx = ((8'h77 >> i) & 8'h01) != 8'h00;
      step(cpb);
    end
    rx = 1'b1;
    step(cpb / 2);
    check("t5 busy_before_rst", {31'd0, rx_busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("t5 rst rx_busy",   {31'd0, rx_busy}, 32'd0);
    check("t5 rst rx_valid",  {31'd0, bus.rx_valid}, 32'd0);
    check("t5 rst rx_data",   {24'd0, bus.rx_data}, 32'd0);
    check("t5 rst frame_err", {31'd0, frame_err}, 32'd0);
    check("t5 rst overrun",   {31'd0, overrun}, 32'd0);
    step(5);
    rst = 1'b1;
    step(100);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    rx = 1'b1;
    step(2 * cpb);
    check("t5 drained", exp_q.size(), 32'd0);

    // 6: one tick per clk, back-to-back frames
    btm = 14'd0;
    cpb = 16;
    step(10);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    rx = 1'b1;
    step(40);
    check("t6 drained", exp_q.size(), 32'd0);
    check("t6 no_frame_err_pending", fe_exp, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
